// File: rtl/group_gather_if.sv
// group_gather_if -- handshake bundle for group_gather.
//   Upstream element stream : up_data, up_last, up_val (to block), up_rdy (from block)
//   Downstream group stream : dn_data, dn_val (from block), dn_rdy (to block)
//   master : the environment side (drives the upstream element, accepts the group)
//   slave  : the gather block itself
interface group_gather_if #(
  parameter int GROUP_NB  = 4,
  parameter int NUM_WIDTH = 16
);
  logic [NUM_WIDTH-1:0]          up_data;
  logic                          up_last;
  logic                          up_val;
  logic                          up_rdy;
  logic [NUM_WIDTH*GROUP_NB-1:0] dn_data;
  logic                          dn_val;
  logic                          dn_rdy;

  modport master (
    output up_data, up_last, up_val, dn_rdy,
    input  up_rdy, dn_data, dn_val
  );

  modport slave (
    input  up_data, up_last, up_val, dn_rdy,
    output up_rdy, dn_data, dn_val
  );
endinterface

// File: rtl/group_gather.sv
// group_gather -- gathers GROUP_NB consecutive signed numbers into one wide word.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : group_gather_if.slave
//         up_data/up_last/up_val/up_rdy : one element per accept; up_last closes early
//         dn_data/dn_val/dn_rdy         : gathered group, lane k at [k*NUM_WIDTH +: NUM_WIDTH]
// A fill register accumulates the current group; a closed group goes straight to
// the output register when that register is free this edge, otherwise it waits in
// the fill register (HOLD) and upstream is stalled until the output frees up.
module group_gather #(
  parameter int GROUP_NB  = 4,
  parameter int NUM_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  group_gather_if.slave bus
);

  localparam int LANE_W  = (GROUP_NB > 1) ? $clog2(GROUP_NB) : 1;
  localparam int GROUP_W = GROUP_NB * NUM_WIDTH;

  typedef enum logic {FILL, HOLD}  fill_state_t;
  typedef enum logic {EMPTY, FULL} out_state_t;

  fill_state_t        fill_state, fill_state_nxt;
  out_state_t         out_state,  out_state_nxt;
  logic [LANE_W-1:0]  lane,       lane_nxt;
  logic [GROUP_W-1:0] fill_data,  fill_data_nxt;
  logic [GROUP_W-1:0] out_data,   out_data_nxt;

  logic               up_rdy;
  logic               accept;
  logic               dn_xfer;
  logic               out_free;
  logic               closing;
  logic [GROUP_W-1:0] merged;

  // up_rdy depends on state and rst only, never on dn_rdy.
  assign up_rdy      = (fill_state == FILL) && !rst;
  assign accept      = bus.up_val && up_rdy;
  assign dn_xfer     = (out_state == FULL) && bus.dn_rdy;
  assign out_free    = (out_state == EMPTY) || dn_xfer;
  assign closing     = accept && ((lane == LANE_W'(GROUP_NB - 1)) || bus.up_last);

  assign bus.up_rdy  = up_rdy;
  assign bus.dn_val  = (out_state == FULL);
  assign bus.dn_data = out_data;

  // Current fill contents with the incoming element placed in its lane. Lanes above
  // the counter are still zero because the fill register is cleared on every close.
  always_comb begin
    merged = fill_data;
    for (int k = 0; k < GROUP_NB; k++) begin
      if (lane == LANE_W'(k)) merged[k*NUM_WIDTH +: NUM_WIDTH] = bus.up_data;
    end
  end

  // NOTE: every next-state variable gets its hold value first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    fill_state_nxt = fill_state;
    out_state_nxt  = out_state;
    lane_nxt       = lane;
    fill_data_nxt  = fill_data;
    out_data_nxt   = out_data;

    // A transfer empties the output unless a new group is loaded on the same edge.
    if (dn_xfer) out_state_nxt = EMPTY;

    case (fill_state)
      FILL: begin
        if (accept) begin
          if (closing) begin
            lane_nxt = '0;
            if (out_free) begin
              out_data_nxt  = merged;
              out_state_nxt = FULL;
              fill_data_nxt = '0;
            end else begin
              fill_data_nxt  = merged;
              fill_state_nxt = HOLD;
            end
          end else begin
            lane_nxt      = lane + LANE_W'(1);
            fill_data_nxt = merged;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          out_data_nxt   = fill_data;
          out_state_nxt  = FULL;
          fill_data_nxt  = '0;
          fill_state_nxt = FILL;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are reset too, so no partial or held group and no
      // stale output word survives a reset.
      fill_state <= FILL;
      out_state  <= EMPTY;
      lane       <= '0;
      fill_data  <= '0;
      out_data   <= '0;
    end else begin
      fill_state <= fill_state_nxt;
      out_state  <= out_state_nxt;
      lane       <= lane_nxt;
      fill_data  <= fill_data_nxt;
      out_data   <= out_data_nxt;
    end
  end

endmodule

// File: tb/tb_group_gather.sv
// tb_group_gather -- directed self-checking bench for group_gather (GROUP_NB=4, Q8.8).
module tb_group_gather;

  localparam int GROUP_NB  = 4;
  localparam int NUM_WIDTH = 16;
  localparam int GROUP_W   = GROUP_NB * NUM_WIDTH;

  logic clk;
  logic rst;

  group_gather_if #(.GROUP_NB(GROUP_NB), .NUM_WIDTH(NUM_WIDTH)) bus ();

  group_gather #(.GROUP_NB(GROUP_NB), .NUM_WIDTH(NUM_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [GROUP_W-1:0] groups[$];
  logic               seen_7fff = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; a negedge sees them settled, so a
  // group visible with dn_rdy high here is transferred on the following edge.
  always @(negedge clk) begin
    if (!rst && bus.dn_val) begin
      for (int k = 0; k < GROUP_NB; k++) begin
        if (bus.dn_data[k*NUM_WIDTH +: NUM_WIDTH] == 16'h7FFF) seen_7fff = 1'b1;
      end
      if (bus.dn_rdy) groups.push_back(bus.dn_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    bus.up_data = d;
    bus.up_last = l;
    bus.up_val  = 1'b1;
    tick();
    bus.up_val  = 1'b0;
    bus.up_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int budget;
    int base;
    logic acc;

    rst         = 1'b1;
    bus.up_data = '0;
    bus.up_last = 1'b0;
    bus.up_val  = 1'b0;
    bus.dn_rdy  = 1'b0;

    // Reset held for 3 cycles.
    tick(); tick(); tick();
    check("rst_up_rdy_low", 64'(bus.up_rdy), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_dn_val", 64'(bus.dn_val), 64'd0);
    check("rst_dn_data", 64'(bus.dn_data), 64'd0);
    check("rst_up_rdy", 64'(bus.up_rdy), 64'd1);

    // Streaming with dn_rdy high: one group every 4 accepts.
    bus.dn_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.up_data = 16'(i << 8);
      bus.up_val  = 1'b1;
      tick();
      if (i == 4) begin
        check("stream_g1_val", 64'(bus.dn_val), 64'd1);
        check("stream_g1_data", 64'(bus.dn_data), 64'h0400_0300_0200_0100);
      end else if (i == 8) begin
        check("stream_g2_val", 64'(bus.dn_val), 64'd1);
        check("stream_g2_data", 64'(bus.dn_data), 64'h0800_0700_0600_0500);
      end else begin
        check($sformatf("stream_idle_%0d", i), 64'(bus.dn_val), 64'd0);
      end
    end
    bus.up_val = 1'b0;
    tick();
    check("stream_drain", 64'(bus.dn_val), 64'd0);

    // Backpressure: two groups fill output + hold, then upstream stalls.
    base       = groups.size();
    bus.dn_rdy = 1'b0;
    idx        = 1;
    budget     = 0;
    while (idx <= 8 && budget < 40) begin
      bus.up_data = 16'(idx << 8);
      bus.up_val  = 1'b1;
      acc         = bus.up_rdy;
      tick();
      if (acc) idx++;
      budget++;
    end
    check("bp_phase1_accepts", 64'(idx), 64'd9);
    check("bp_up_rdy_low", 64'(bus.up_rdy), 64'd0);
    for (int c = 0; c < 4; c++) begin
      bus.up_data = (c < 2) ? 16'h0900 : 16'h7FFF;
      bus.up_last = (c >= 2);
      bus.up_val  = 1'b1;
      tick();
      check($sformatf("bp_stall_rdy_%0d", c), 64'(bus.up_rdy), 64'd0);
      check($sformatf("bp_stall_out_%0d", c), 64'(bus.dn_data), 64'h0400_0300_0200_0100);
      check($sformatf("bp_stall_val_%0d", c), 64'(bus.dn_val), 64'd1);
    end
    bus.up_last = 1'b0;
    bus.dn_rdy  = 1'b1;
    budget      = 0;
    while (idx <= 12 && budget < 40) begin
      bus.up_data = 16'(idx << 8);
      bus.up_val  = 1'b1;
      acc         = bus.up_rdy;
      tick();
      if (acc) idx++;
      budget++;
    end
    check("bp_phase2_accepts", 64'(idx), 64'd13);
    bus.up_val = 1'b0;
    tick(); tick(); tick();
    check("bp_group_count", 64'(groups.size() - base), 64'd3);
    if (groups.size() - base >= 3) begin
      check("bp_group1", 64'(groups[base]),     64'h0400_0300_0200_0100);
      check("bp_group2", 64'(groups[base + 1]), 64'h0800_0700_0600_0500);
      check("bp_group3", 64'(groups[base + 2]), 64'h0C00_0B00_0A00_0900);
    end
    check("bp_idle", 64'(bus.dn_val), 64'd0);

    // Early close with up_last; the next element restarts at lane 0.
    send(16'h0900, 1'b0);
    check("early_partial_idle", 64'(bus.dn_val), 64'd0);
    send(16'h0A00, 1'b1);
    check("early_val", 64'(bus.dn_val), 64'd1);
    check("early_data", 64'(bus.dn_data), 64'h0000_0000_0A00_0900);
    send(16'h0B00, 1'b1);
    check("early_next_lane0", 64'(bus.dn_data), 64'h0000_0000_0000_0B00);
    tick();
    check("early_drain", 64'(bus.dn_val), 64'd0);

    // Reset mid-group discards the partial group.
    base = groups.size();
    send(16'h1100, 1'b0);
    send(16'h1200, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_up_rdy", 64'(bus.up_rdy), 64'd0);
    check("midrst_dn_val", 64'(bus.dn_val), 64'd0);
    rst = 1'b0;
    #1;
    check("midrst_rdy_after", 64'(bus.up_rdy), 64'd1);
    for (int i = 13; i <= 16; i++) send(16'(i << 8), 1'b0);
    tick(); tick(); tick();
    check("midrst_group_count", 64'(groups.size() - base), 64'd1);
    if (groups.size() > base) begin
      check("midrst_group", 64'(groups[base]), 64'h1000_0F00_0E00_0D00);
    end

    check("no_7fff_output", 64'(seen_7fff), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
